// File: rtl/env_mixer_pkg.sv
// Shared constants and state type for the four-voice envelope mixer.
package env_mixer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_t;

  localparam logic [3:0]  ENV_MAX    = 4'd15;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Fibonacci taps 16,14,13,11 as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

endpackage

// File: rtl/env_voice.sv
// One voice: ADSR-style envelope FSM and its 4-bit level, stepped on sample strobes.
module env_voice
  import env_mixer_pkg::*;
#(
  parameter int unsigned ATTACK_STEP = 1,
  parameter int unsigned SUSTAIN     = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i_ena,
  input  logic       i_tick,
  input  logic       i_rise,
  input  logic       i_fall,
  output logic [3:0] o_env,
  output logic       o_busy
);

  localparam logic [3:0] SUST4 = 4'(SUSTAIN);

  env_state_t r_state, w_state_nxt;
  logic [3:0] r_env, w_env_nxt;
  logic [4:0] w_att;
  logic [3:0] w_att_sat;
  logic [3:0] w_dec;

  assign w_att     = {1'b0, r_env} + 5'(ATTACK_STEP);
  assign w_att_sat = (w_att > {1'b0, ENV_MAX}) ? ENV_MAX : w_att[3:0];
  assign w_dec     = r_env - 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_env   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_env   <= w_env_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_env_nxt   = r_env;
    if (i_ena) begin
      // Gate edges take precedence; the level is kept on retrigger.
      if (i_rise) begin
        w_state_nxt = ST_ATTACK;
      end else if (i_fall && (r_state == ST_ATTACK || r_state == ST_DECAY ||
                              r_state == ST_SUSTAIN)) begin
        w_state_nxt = ST_RELEASE;
      end else begin
        case (r_state)
          ST_ATTACK: begin
            if (i_tick) begin
              w_env_nxt = w_att_sat;
              if (w_att_sat == ENV_MAX) w_state_nxt = ST_DECAY;
            end
          end
          ST_DECAY: begin
            if (r_env <= SUST4) begin
              w_state_nxt = ST_SUSTAIN;
            end else if (i_tick) begin
              w_env_nxt = w_dec;
              if (w_dec <= SUST4) w_state_nxt = ST_SUSTAIN;
            end
          end
          ST_RELEASE: begin
            if (r_env == '0) begin
              w_state_nxt = ST_IDLE;
            end else if (i_tick) begin
              w_env_nxt = w_dec;
              if (w_dec == '0) w_state_nxt = ST_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_env  = r_env;
  assign o_busy = (r_state != ST_IDLE);

endmodule

// File: rtl/env_mixer.sv
// Four-voice envelope mixer: gate edge detect, shared envelope divider, 2-stage mix.
// Optional dither on the final shift is enabled with `define MIXER_DITHER_EN.
module env_mixer
  import env_mixer_pkg::*;
#(
  parameter int unsigned ENV_DIV     = 64,
  parameter int unsigned ATTACK_STEP = 1,
  parameter int unsigned SUSTAIN     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_ena,
  input  logic [15:0] voices,
  input  logic [3:0]  gate,
  output logic [3:0]  sample,
  output logic [15:0] env_o,
  output logic        busy
);

  localparam logic [11:0] DIV_LAST = 12'(ENV_DIV - 1);

  logic [3:0]  r_gate_q;
  logic [11:0] r_div;
  logic        r_ena_d;
  logic [3:0]  r_p [4];
  logic        w_tick;
  logic [3:0]  w_rise, w_fall, w_busy;
  logic [7:0]  w_prod [4];
  logic [5:0]  w_sum;
  logic [3:0]  w_sample;

  assign w_rise = gate & ~r_gate_q;
  assign w_fall = ~gate & r_gate_q;
  assign w_tick = sample_ena && (r_div == DIV_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_gate_q <= '0;
      r_div    <= '0;
    end else if (sample_ena) begin
      r_gate_q <= gate;
      r_div    <= (r_div == DIV_LAST) ? '0 : r_div + 12'd1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_voice
    env_voice #(
      .ATTACK_STEP(ATTACK_STEP),
      .SUSTAIN    (SUSTAIN)
    ) u_voice (
      .clock (clock),
      .reset (reset),
      .i_ena (sample_ena),
      .i_tick(w_tick),
      .i_rise(w_rise[g]),
      .i_fall(w_fall[g]),
      .o_env (env_o[4*g +: 4]),
      .o_busy(w_busy[g])
    );
    assign w_prod[g] = {4'b0, voices[4*g +: 4]} * {4'b0, env_o[4*g +: 4]};
  end

  assign busy = |w_busy;

  // Stage 1 captures products with the envelope levels from before this strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < 4; k++) r_p[k] <= '0;
      r_ena_d <= 1'b0;
    end else begin
      r_ena_d <= sample_ena;
      if (sample_ena) begin
        for (int unsigned k = 0; k < 4; k++) r_p[k] <= 4'(w_prod[k] >> 4);
      end
    end
  end

  always_comb begin
    w_sum = '0;
    for (int unsigned k = 0; k < 4; k++) w_sum = w_sum + 6'(r_p[k]);
  end

`ifdef MIXER_DITHER_EN
  logic [15:0] r_lfsr;
  logic [6:0]  w_dsum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else if (sample_ena) r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_dsum   = 7'(w_sum) + 7'(r_lfsr[1:0]);
  assign w_sample = ((w_dsum >> 2) > 7'd15) ? 4'd15 : 4'(w_dsum >> 2);
`else
  assign w_sample = 4'(w_sum >> 2);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sample <= '0;
    else if (r_ena_d) sample <= w_sample;
  end

endmodule

// File: tb/tb_env_mixer.sv
// Self-checking bench: two mixers (ENV_DIV 1 and 4) against a behavioural envelope model.
module tb_env_mixer;

  logic        clock = 1'b0;
  logic        reset;
  logic        sample_ena;
  logic [15:0] voices;
  logic [3:0]  gate;
  logic [3:0]  sample_a, sample_b;
  logic [15:0] env_a, env_b;
  logic        busy_a, busy_b;

  always #5 clock = ~clock;

  env_mixer #(.ENV_DIV(1), .ATTACK_STEP(1), .SUSTAIN(8)) u_dut_d1 (
    .clock(clock), .reset(reset), .sample_ena(sample_ena), .voices(voices),
    .gate(gate), .sample(sample_a), .env_o(env_a), .busy(busy_a));

  env_mixer #(.ENV_DIV(4), .ATTACK_STEP(1), .SUSTAIN(8)) u_dut_d4 (
    .clock(clock), .reset(reset), .sample_ena(sample_ena), .voices(voices),
    .gate(gate), .sample(sample_b), .env_o(env_b), .busy(busy_b));

  localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;
  localparam int M_SUSTAIN = 8, M_STEP = 1;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_st  [2][4];
  int          m_env [2][4];
  int          m_div [2];
  logic [3:0]  m_gq  [2];
  int          m_sample [2];
  logic [15:0] m_lfsr [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [15:0] exp_env(input int i);
    logic [15:0] e;
    e = '0;
    for (int v = 0; v < 4; v++) e[4*v +: 4] = 4'(m_env[i][v]);
    return e;
  endfunction

  function automatic logic exp_busy(input int i);
    logic b;
    b = 1'b0;
    for (int v = 0; v < 4; v++) if (m_st[i][v] != M_IDLE) b = 1'b1;
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 4; v++) begin
        m_st[i][v]  = M_IDLE;
        m_env[i][v] = 0;
      end
      m_div[i]    = 0;
      m_gq[i]     = '0;
      m_sample[i] = 0;
      m_lfsr[i]   = 16'hACE1;
    end
  endtask

  task automatic model_pulse(input int i);
    int   sum, e;
    logic tick, rise, fall, fb;
    sum = 0;
    for (int v = 0; v < 4; v++) sum += (int'(voices[4*v +: 4]) * m_env[i][v]) / 16;
`ifdef MIXER_DITHER_EN
    fb = m_lfsr[i][15] ^ m_lfsr[i][13] ^ m_lfsr[i][12] ^ m_lfsr[i][10];
    m_lfsr[i] = {m_lfsr[i][14:0], fb};
    m_sample[i] = (sum + int'(m_lfsr[i][1:0])) / 4;
    if (m_sample[i] > 15) m_sample[i] = 15;
`else
    fb = 1'b0;
    m_sample[i] = sum / 4;
`endif
    tick = (m_div[i] == div_of(i) - 1);
    m_div[i] = tick ? 0 : m_div[i] + 1;
    for (int v = 0; v < 4; v++) begin
      rise = gate[v] && !m_gq[i][v];
      fall = !gate[v] && m_gq[i][v];
      e = m_env[i][v];
      if (rise) m_st[i][v] = M_ATT;
      else if (fall && m_st[i][v] inside {M_ATT, M_DEC, M_SUS}) m_st[i][v] = M_REL;
      else if (m_st[i][v] == M_ATT && tick) begin
        e = (e + M_STEP > 15) ? 15 : e + M_STEP;
        if (e == 15) m_st[i][v] = M_DEC;
      end else if (m_st[i][v] == M_DEC) begin
        if (e <= M_SUSTAIN) m_st[i][v] = M_SUS;
        else if (tick) begin
          e = e - 1;
          if (e <= M_SUSTAIN) m_st[i][v] = M_SUS;
        end
      end else if (m_st[i][v] == M_REL) begin
        if (e == 0) m_st[i][v] = M_IDLE;
        else if (tick) begin
          e = e - 1;
          if (e == 0) m_st[i][v] = M_IDLE;
        end
      end
      m_env[i][v] = e;
    end
    m_gq[i] = gate;
  endtask

  // One strobe, then two quiet cycles: checks envelopes, hold of the old sample, new sample.
  task automatic pulse();
    int prev_a, prev_b;
    @(negedge clock);
    sample_ena = 1'b1;
    prev_a = m_sample[0];
    prev_b = m_sample[1];
    model_pulse(0);
    model_pulse(1);
    @(negedge clock);
    sample_ena = 1'b0;
    check("env_d1", env_a, exp_env(0));
    check("env_d4", env_b, exp_env(1));
    check("busy_d1", busy_a, exp_busy(0));
    check("busy_d4", busy_b, exp_busy(1));
    check("hold_d1", sample_a, prev_a);
    check("hold_d4", sample_b, prev_b);
    @(negedge clock);
    check("mix_d1", sample_a, m_sample[0]);
    check("mix_d4", sample_b, m_sample[1]);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    sample_ena = 1'b0;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sample_ena = 1'b0;
    voices = '0;
    gate = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    check("rst_sample", sample_a, 0);
    check("rst_env", env_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_env_d4", env_b, 0);

    // Attack ramp 1..15, decay to sustain 8 and hold
    voices = 16'h000F;
    gate = 4'b0001;
    pulse();
    for (int t = 1; t <= 15; t++) begin
      pulse();
      check("att_ramp", env_a[3:0], t);
    end
    for (int t = 1; t <= 7; t++) begin
      pulse();
      check("decay", env_a[3:0], 15 - t);
    end
    repeat (3) begin
      pulse();
      check("sustain", env_a[3:0], 8);
    end

    // Release to idle, then gate fall mid-attack at env 5
    gate = 4'b0000;
    repeat (9) pulse();
    check("idle_env", env_a[3:0], 0);
    gate = 4'b0001;
    repeat (6) pulse();
    check("att5", env_a[3:0], 5);
    gate = 4'b0000;
    pulse();
    check("rel_enter", env_a[3:0], 5);
    for (int t = 4; t >= 0; t--) begin
      pulse();
      check("rel_ramp", env_a[3:0], t);
    end
    check("busy_drop", busy_a, 0);

    // Retrigger during release at env 6
    gate = 4'b0001;
    repeat (23) pulse();
    check("sus_again", env_a[3:0], 8);
    gate = 4'b0000;
    repeat (3) pulse();
    check("rel6", env_a[3:0], 6);
    gate = 4'b0001;
    pulse();
    check("retrig_keep", env_a[3:0], 6);
    repeat (8) pulse();
    check("retrig8", env_a[3:0], 14);
    pulse();
    check("retrig9", env_a[3:0], 15);

    // Full-scale mix on all voices
    apply_reset();
    voices = 16'hFFFF;
    gate = 4'hF;
    repeat (16) pulse();
    check("all15", env_a, 16'hFFFF);
    pulse();
    check("full_mix", sample_a, 14);

    // ENV_DIV=4: gate rise coincident with the 4th strobe's tick
    apply_reset();
    gate = 4'h0;
    repeat (3) pulse();
    gate = 4'h1;
    pulse();
    check("edge_wins", env_b[3:0], 0);
    repeat (3) begin
      pulse();
      check("d4_wait", env_b[3:0], 0);
    end
    pulse();
    check("d4_step", env_b[3:0], 1);

    // Asynchronous reset mid-decay
    apply_reset();
    voices = 16'h000F;
    gate = 4'h1;
    repeat (18) pulse();
    check("pre_rst_env", env_a[3:0], 13);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_env", env_a, 0);
    check("arst_sample", sample_a, 0);
    check("arst_busy", busy_a, 0);
    check("arst_env_d4", env_b, 0);
    @(negedge clock);
    sample_ena = 1'b0;
    model_reset();
    reset = 1'b0;

    // Randomised gates and voices, with occasional resets
    for (int n = 0; n < 360; n++) begin
      if (n % 120 == 119) apply_reset();
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) gate[b] = ~gate[b];
      voices = 16'($urandom);
      pulse();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
